rv_mem_arb: RTL and testbench

RV_MEM_ARB -- requirements
Module: rv_mem_arb

---
 rtl/rv_mem_arb.sv | 172 +++++++++++++++++
 tb/tb_rv_mem_arb.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_mem_arb.sv
// Two-port (core / DMA) arbiter onto a single fixed-latency memory, one transaction in flight.
// Latency: request sampled in IDLE -> grant next cycle, done MEM_LAT+2 cycles after the sample edge.
// Backpressure: requests are only sampled in IDLE; a requester simply holds req until it sees gnt.
//
// Optional feature: define RV_MEM_ARB_CORE_PRIO_EN to give the core fixed priority on ties
// (default build is round-robin via a 1-bit last-winner pointer).
//
// Ports:
//   clk, rst                         clock, synchronous active-low reset
//   c_req/c_we/c_addr/c_wdata        core command in
//   c_gnt/c_done/c_rdata             core grant pulse, completion pulse, registered read data
//   d_*                              DMA port, same shape as the core port
//   mem_en/mem_we/mem_addr/mem_wdata memory command out (strobe only in ACCESS)
//   mem_rdata                        memory read data, valid MEM_LAT cycles after mem_en
//   busy                             high whenever the FSM is not IDLE
module rv_mem_arb #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_gnt,
  output logic        c_done,
  output logic [31:0] c_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCESS = 3'd1,
    WAIT   = 3'd2,
    CAPT   = 3'd3,
    DONE   = 3'd4
  } state_e;

  // WAIT lasts MEM_LAT-1 cycles: load MEM_LAT-2 and leave when the counter reads zero.
  localparam logic [3:0] WAIT_INIT = (MEM_LAT > 1) ? 4'(MEM_LAT - 2) : 4'd0;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        lw_q, lw_d;        // last winner: 0 = core, 1 = DMA
  logic        id_q, id_d;        // current owner: 0 = core, 1 = DMA
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] c_rdata_q, c_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        pick_dma;

  // DMA wins when it is the only requester, or on a tie when the core won last.
`ifdef RV_MEM_ARB_CORE_PRIO_EN
  assign pick_dma = d_req & ~c_req;
`else
  assign pick_dma = d_req & (~c_req | ~lw_q);
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lw_d      = lw_q;
    id_d      = id_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    c_rdata_d = c_rdata_q;
    d_rdata_d = d_rdata_q;
    c_gnt     = 1'b0;
    d_gnt     = 1'b0;
    c_done    = 1'b0;
    d_done    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;

    case (state_q)
      IDLE: begin
        if (c_req || d_req) begin
          id_d    = pick_dma;
          we_d    = pick_dma ? d_we    : c_we;
          addr_d  = pick_dma ? d_addr  : c_addr;
          wdata_d = pick_dma ? d_wdata : c_wdata;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        c_gnt  = ~id_q;
        d_gnt  = id_q;
        mem_en = 1'b1;
        mem_we = we_q;
        lw_d   = id_q;
        if (MEM_LAT > 1) begin
          cnt_d   = WAIT_INIT;
          state_d = WAIT;
        end else begin
          state_d = CAPT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = CAPT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      CAPT: begin
        // Only the owner's register moves, and only for a read.
        if (!we_q) begin
          if (id_q) begin
            d_rdata_d = mem_rdata;
          end else begin
            c_rdata_d = mem_rdata;
          end
        end
        state_d = DONE;
      end
      DONE: begin
        c_done  = ~id_q;
        d_done  = id_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      lw_q      <= 1'b1;              // DMA "won last" so the core takes the first tie
      id_q      <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      c_rdata_q <= 32'd0;
      d_rdata_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lw_q      <= lw_d;
      id_q      <= id_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      c_rdata_q <= c_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Address/data come straight from the latched command, so they hold outside ACCESS.
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign c_rdata   = c_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_rv_mem_arb.sv
// Bench for rv_mem_arb: instance A at MEM_LAT=2 with a completion scoreboard,
// instance B at MEM_LAT=1 checked by directed steps.
module tb_rv_mem_arb;

  localparam int A_LAT = 2;
  localparam int B_LAT = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  // instance A
  logic        c_req, c_we, d_req, d_we;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic        c_gnt, c_done, d_gnt, d_done, mem_en, mem_we, busy;
  logic [31:0] c_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  // instance B
  logic        b_c_req, b_c_we, b_d_req, b_d_we;
  logic [31:0] b_c_addr, b_c_wdata, b_d_addr, b_d_wdata;
  logic        b_c_gnt, b_c_done, b_d_gnt, b_d_done, b_mem_en, b_mem_we, b_busy;
  logic [31:0] b_c_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

  rv_mem_arb #(.MEM_LAT(A_LAT)) u_a (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_done(c_done), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  rv_mem_arb #(.MEM_LAT(B_LAT)) u_b (
    .clk(clk), .rst(rst),
    .c_req(b_c_req), .c_we(b_c_we), .c_addr(b_c_addr), .c_wdata(b_c_wdata),
    .c_gnt(b_c_gnt), .c_done(b_c_done), .c_rdata(b_c_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_gnt(b_d_gnt), .d_done(b_d_done), .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a ^ 32'h5A00_00C3) + 32'h0000_1111;
  endfunction

  // Memory models: data is valid only in the exact cycle MEM_LAT after a read strobe,
  // otherwise a poison value shows up.
  logic [1:0]  pa_v = 2'b00;
  logic [31:0] pa_d0 = 32'd0, pa_d1 = 32'd0;
  always @(posedge clk) begin
    pa_v  <= {pa_v[0], mem_en & ~mem_we};
    pa_d0 <= mem_f(mem_addr);
    pa_d1 <= pa_d0;
  end
  assign mem_rdata = pa_v[A_LAT-1] ? pa_d1 : 32'hBAD0_0BAD;

  logic        pb_v = 1'b0;
  logic [31:0] pb_d = 32'd0;
  always @(posedge clk) begin
    pb_v <= b_mem_en & ~b_mem_we;
    pb_d <= mem_f(b_mem_addr);
  end
  assign b_mem_rdata = pb_v ? pb_d : 32'hBAD1_1BAD;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  // Scoreboard: one entry per expected completion on instance A.
  typedef struct {
    logic        port;   // 0 = core, 1 = DMA
    logic        we;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic [31:0] exp_c = 32'd0;
  logic [31:0] exp_d = 32'd0;

  always @(negedge clk) begin
    if (c_done || d_done) begin
      if (sbq.size() == 0) begin
        chk1("unexpected_done", 1'b1, 1'b0);
      end else begin
        mon_e = sbq.pop_front();
        chk1("done_c", c_done, ~mon_e.port);
        chk1("done_d", d_done, mon_e.port);
        chk("done_cycle", cyc, mon_e.cyc);
        if (!mon_e.we) begin
          if (mon_e.port) exp_d = mon_e.rdata;
          else            exp_c = mon_e.rdata;
        end
        chk("c_rdata", c_rdata, exp_c);
        chk("d_rdata", d_rdata, exp_d);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    chk1(tag, busy, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    c_req = 1'b0; d_req = 1'b0; c_we = 1'b0; d_we = 1'b0;
    step();
    step();
    exp_c = 32'd0;
    exp_d = 32'd0;
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int   base;
  logic port;

  initial begin
    rst = 1'b0;
    c_req = 1'b0; c_we = 1'b0; c_addr = 32'd0; c_wdata = 32'd0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
    b_c_req = 1'b0; b_c_we = 1'b0; b_c_addr = 32'd0; b_c_wdata = 32'd0;
    b_d_req = 1'b0; b_d_we = 1'b0; b_d_addr = 32'd0; b_d_wdata = 32'd0;
    step();
    step();

    // Reset values
    chk("rst_pulses", {25'd0, c_gnt, d_gnt, c_done, d_done, mem_en, mem_we, busy}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_c_rdata", c_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk1("rst_b_busy", b_busy, 1'b0);

    // Core read of 0x100; request dropped right after grant must still complete
    rst = 1'b1;
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h100;
    base = cyc;
    sbq.push_back('{1'b0, 1'b0, 32'hDEADBEEF, base + A_LAT + 2});
    step();
    chk1("t1_c_gnt", c_gnt, 1'b1);
    chk1("t1_d_gnt", d_gnt, 1'b0);
    chk1("t1_mem_en", mem_en, 1'b1);
    chk1("t1_mem_we", mem_we, 1'b0);
    chk("t1_mem_addr", mem_addr, 32'h100);
    chk1("t1_busy", busy, 1'b1);
    c_req = 1'b0;
    step();
    chk1("t1_gnt_pulse", c_gnt, 1'b0);
    chk1("t1_mem_en_low", mem_en, 1'b0);
    wait_idle("t1_idle");
    chk("t1_idle_cycle", cyc, base + A_LAT + 3);
    chk("t1_c_rdata", c_rdata, 32'hDEADBEEF);

    // Core write: rdata registers untouched, address/data hold after ACCESS
    c_req = 1'b1; c_we = 1'b1; c_addr = 32'h20; c_wdata = 32'h12345678;
    base = cyc;
    sbq.push_back('{1'b0, 1'b1, 32'd0, base + A_LAT + 2});
    step();
    chk1("t2_c_gnt", c_gnt, 1'b1);
    chk1("t2_mem_we", mem_we, 1'b1);
    chk("t2_mem_addr", mem_addr, 32'h20);
    chk("t2_mem_wdata", mem_wdata, 32'h12345678);
    c_req = 1'b0; c_we = 1'b0;
    step();
    chk1("t2_we_low", mem_we, 1'b0);
    chk("t2_addr_hold", mem_addr, 32'h20);
    chk("t2_wdata_hold", mem_wdata, 32'h12345678);
    wait_idle("t2_idle");
    chk("t2_c_rdata", c_rdata, 32'hDEADBEEF);

    // Simultaneous reads from reset: core first, DMA after a pass through IDLE
    do_reset();
    chk("t3_rst_rdata", c_rdata, 32'd0);
    c_req = 1'b1; c_addr = 32'h200;
    d_req = 1'b1; d_addr = 32'h300; d_we = 1'b0;
    base = cyc;
    sbq.push_back('{1'b0, 1'b0, mem_f(32'h200), base + 4});
    sbq.push_back('{1'b1, 1'b0, mem_f(32'h300), base + 9});
    step();
    chk("t3_first_gnt", {30'd0, c_gnt, d_gnt}, 32'd2);
    repeat (4) step();
    chk1("t3_gap_idle", busy, 1'b0);
    step();
    chk("t3_second_gnt", {30'd0, c_gnt, d_gnt}, 32'd1);
    chk("t3_dma_addr", mem_addr, 32'h300);
    c_req = 1'b0; d_req = 1'b0;
    wait_idle("t3_idle");
    chk("t3_idle_cycle", cyc, base + 10);

    // Four back-to-back ties
    do_reset();
    c_req = 1'b1; c_addr = 32'h400;
    d_req = 1'b1; d_addr = 32'h500;
    base = cyc;
    for (int i = 0; i < 4; i++) begin
`ifdef RV_MEM_ARB_CORE_PRIO_EN
      port = 1'b0;
`else
      port = (i % 2) == 1;
`endif
      sbq.push_back('{port, 1'b0, mem_f(port ? 32'h500 : 32'h400), base + 4 + 5 * i});
    end
    for (int i = 0; i < 4; i++) begin
`ifdef RV_MEM_ARB_CORE_PRIO_EN
      port = 1'b0;
`else
      port = (i % 2) == 1;
`endif
      step();
      chk("t4_gnt", {30'd0, c_gnt, d_gnt}, port ? 32'd1 : 32'd2);
      repeat (4) step();
    end
    c_req = 1'b0; d_req = 1'b0;
    wait_idle("t4_idle");
    step();
    chk1("t4_no_extra", busy, 1'b0);

    // Reset during WAIT: access abandoned, held request re-arbitrated after release
    c_req = 1'b1; c_addr = 32'h600;
    step();
    step();
    chk1("t5_in_wait", busy, 1'b1);
    rst = 1'b0;
    step();
    chk1("t5_busy", busy, 1'b0);
    chk("t5_pulses", {26'd0, c_gnt, d_gnt, c_done, d_done, mem_en, mem_we}, 32'd0);
    chk("t5_mem_addr", mem_addr, 32'd0);
    chk("t5_c_rdata", c_rdata, 32'd0);
    exp_c = 32'd0;
    exp_d = 32'd0;
    rst = 1'b1;
    base = cyc;
    sbq.push_back('{1'b0, 1'b0, mem_f(32'h600), base + 4});
    step();
    chk1("t5_regrant", c_gnt, 1'b1);
    c_req = 1'b0;
    wait_idle("t5_idle");
    chk("t5_idle_cycle", cyc, base + 5);

    // MEM_LAT=1 instance: no WAIT state
    b_c_req = 1'b1; b_c_addr = 32'h100;
    step();
    chk1("t6_gnt", b_c_gnt, 1'b1);
    chk1("t6_mem_en", b_mem_en, 1'b1);
    chk1("t6_d_gnt", b_d_gnt, 1'b0);
    b_c_req = 1'b0;
    step();
    chk1("t6_no_early_done", b_c_done, 1'b0);
    step();
    chk1("t6_done", b_c_done, 1'b1);
    chk1("t6_d_done", b_d_done, 1'b0);
    chk("t6_c_rdata", b_c_rdata, 32'hDEADBEEF);
    chk("t6_d_rdata", b_d_rdata, 32'd0);
    step();
    chk1("t6_idle", b_busy, 1'b0);
    chk({"t6_mem_we_wdata"}, {b_mem_wdata[31:1], b_mem_wdata[0] | b_mem_we}, 32'd0);

    chk("sb_empty", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
